// File: rtl/irq_ack_master_pkg.sv
// Shared definitions for the interrupt acknowledge master.
//   iack_state_e    : acknowledge sequencer states
//   IACK_ADDR_HI    : fixed upper bits of the acknowledge address
//   AUTOVECTOR_BASE : vector number of autovectored level 0
package irq_ack_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUS = 3'd1,
        ST_ADDR     = 3'd2,
        ST_STROBE   = 3'd3,
        ST_DONE     = 3'd4
    } iack_state_e;

    localparam logic [19:0] IACK_ADDR_HI    = 20'hFFFFF;
    localparam logic [7:0]  AUTOVECTOR_BASE = 8'd24;

endpackage

// File: rtl/irq_ack_master_ipl_sync.sv
// Interrupt priority level synchroniser, debouncer and NMI arming.
//   clk         : system clock
//   _reset      : asynchronous active-low reset
//   _ipl        : raw active-low priority lines
//   nmi_clr_i   : a level-7 request has just been accepted
//   level_o     : synchronised level (true polarity)
//   valid_o     : level_o matched on two consecutive samples
//   nmi_armed_o : a level-7 request may be accepted
module ipl_sync
    import irq_ack_master_pkg::*;
(
    input  logic       clk,
    input  logic       _reset,
    input  logic [2:0] _ipl,
    input  logic       nmi_clr_i,
    output logic [2:0] level_o,
    output logic       valid_o,
    output logic       nmi_armed_o
);

    logic [2:0] sync1_q, sync2_q, prev_q;
    logic       nmi_armed_q, nmi_armed_d;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            prev_q      <= 3'b111;
            nmi_armed_q <= 1'b1;
        end else begin
            sync1_q     <= _ipl;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            nmi_armed_q <= nmi_armed_d;
        end
    end

    assign level_o = ~sync2_q;
    assign valid_o = (sync2_q == prev_q);

    // Re-arm only once a stable level below 7 is seen, so level 7 acts on edges.
    always_comb begin
        nmi_armed_d = nmi_armed_q;
        if (nmi_clr_i) begin
            nmi_armed_d = 1'b0;
        end else if (valid_o && (level_o != 3'd7)) begin
            nmi_armed_d = 1'b1;
        end
    end

    assign nmi_armed_o = nmi_armed_q;

endmodule

// File: rtl/irq_ack_master.sv
// Interrupt acknowledge master: accepts a debounced priority level, waits for
// the bus, runs an acknowledge cycle and captures the returned vector.
//   clk, _reset        : clock, asynchronous active-low reset
//   _ipl, mask         : active-low request level, current CPU mask
//   bus_busy           : CPU bus cycle in progress
//   dtack, avec        : vectored / autovectored response
//   data_in            : responder data, vector in [7:0]
//   iack_address       : acknowledge address [23:1]
//   _iack_as, iack_rd  : address strobe (active-low), read qualifier
//   vector, vector_valid, level, busy : results and status
module irq_ack_master
    import irq_ack_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter logic [7:0]  SPURIOUS_VECTOR = 8'h18
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic [2:0]  _ipl,
    input  logic [2:0]  mask,
    input  logic        bus_busy,
    input  logic        dtack,
    input  logic        avec,
    input  logic [15:0] data_in,
    output logic [22:0] iack_address,
    output logic        _iack_as,
    output logic        iack_rd,
    output logic [7:0]  vector,
    output logic        vector_valid,
    output logic [2:0]  level,
    output logic        busy
);

    localparam logic [7:0] TMO = (TIMEOUT_CYCLES > 255) ? 8'hFF : 8'(TIMEOUT_CYCLES);

    iack_state_e state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  vector_q, vector_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [2:0]  sync_level;
    logic        sync_valid, nmi_armed, nmi_clr, lvl_ok;
    logic        unused_data_hi;

    assign unused_data_hi = ^data_in[15:8];

    ipl_sync u_ipl_sync (
        .clk         (clk),
        ._reset      (_reset),
        ._ipl        (_ipl),
        .nmi_clr_i   (nmi_clr),
        .level_o     (sync_level),
        .valid_o     (sync_valid),
        .nmi_armed_o (nmi_armed)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            vector_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            vector_q <= vector_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign lvl_ok  = sync_valid &&
                     ((sync_level == 3'd7) ? nmi_armed : (sync_level > mask));

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        vector_d = vector_q;
        cnt_d    = '0;
        nmi_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lvl_ok) begin
                    state_d = ST_WAIT_BUS;
                    level_d = sync_level;
                    nmi_clr = (sync_level == 3'd7);
                end
            end
            ST_WAIT_BUS: begin
                if (!bus_busy) state_d = ST_ADDR;
            end
            ST_ADDR: state_d = ST_STROBE;
            ST_STROBE: begin
                cnt_d = cnt_inc;
                if (avec) begin
                    vector_d = AUTOVECTOR_BASE + {5'b0, level_q};
                    state_d  = ST_DONE;
                end else if (dtack) begin
                    vector_d = data_in[7:0];
                    state_d  = ST_DONE;
                end else if (cnt_inc >= TMO) begin
                    vector_d = SPURIOUS_VECTOR;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decode the registered state so the async reset releases them at once.
    always_comb begin
        iack_address = '0;
        iack_rd      = 1'b0;
        _iack_as     = 1'b1;
        if ((state_q == ST_ADDR) || (state_q == ST_STROBE)) begin
            iack_address = {IACK_ADDR_HI, level_q};
            iack_rd      = 1'b1;
        end
        if (state_q == ST_STROBE) _iack_as = 1'b0;
    end

    assign vector_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign vector       = vector_q;
    assign level        = level_q;

endmodule

// File: tb/tb_irq_ack_master.sv
module tb_irq_ack_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ipl_n;
    logic [2:0]  mask;
    logic        bus_busy, dtack, avec;
    logic [15:0] data_in;
    logic [22:0] iack_address;
    logic        iack_as_n, iack_rd;
    logic [7:0]  vector;
    logic        vector_valid;
    logic [2:0]  level;
    logic        busy;

    int checks = 0;
    int errors = 0;

    irq_ack_master #(.TIMEOUT_CYCLES(255), .SPURIOUS_VECTOR(8'h18)) dut (
        .clk          (clk),
        ._reset       (rst_n),
        ._ipl         (ipl_n),
        .mask         (mask),
        .bus_busy     (bus_busy),
        .dtack        (dtack),
        .avec         (avec),
        .data_in      (data_in),
        .iack_address (iack_address),
        ._iack_as     (iack_as_n),
        .iack_rd      (iack_rd),
        .vector       (vector),
        .vector_valid (vector_valid),
        .level        (level),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_as_low(input string tag);
        int n = 0;
        while (iack_as_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, iack_as_n === 1'b0}, 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy === 1'b1}, 32'd1);
    endtask

    task automatic count_busy(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0) hits++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int n;
        rst_n = 1'b0; ipl_n = 3'b111; mask = 3'd7;
        bus_busy = 1'b0; dtack = 1'b0; avec = 1'b0; data_in = '0;
        cyc(3);
        check("rst_as",    {31'b0, iack_as_n}, 32'd1);
        check("rst_rd",    {31'b0, iack_rd}, 32'd0);
        check("rst_addr",  {9'b0, iack_address}, 32'd0);
        check("rst_vec",   {24'b0, vector}, 32'd0);
        check("rst_vv",    {31'b0, vector_valid}, 32'd0);
        check("rst_level", {29'b0, level}, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);

        // Vectored level 3, dtack in the second strobe cycle
        rst_n = 1'b1; mask = 3'd2; ipl_n = 3'b100;
        cyc(3);
        check("v3_no_early_accept", {31'b0, busy}, 32'd0);
        cyc(1);
        check("v3_waitbus_busy", {31'b0, busy}, 32'd1);
        check("v3_waitbus_rd",   {31'b0, iack_rd}, 32'd0);
        cyc(1);
        check("v3_addr_addr", {9'b0, iack_address}, 32'h7FFFFB);
        check("v3_addr_rd",   {31'b0, iack_rd}, 32'd1);
        check("v3_addr_as",   {31'b0, iack_as_n}, 32'd1);
        cyc(1);
        check("v3_strobe1_as", {31'b0, iack_as_n}, 32'd0);
        ipl_n = 3'b111;
        cyc(1);
        check("v3_strobe2_as",   {31'b0, iack_as_n}, 32'd0);
        check("v3_strobe2_addr", {9'b0, iack_address}, 32'h7FFFFB);
        dtack = 1'b1; data_in = 16'h0040;
        cyc(1);
        dtack = 1'b0; data_in = '0;
        check("v3_done_vv",    {31'b0, vector_valid}, 32'd1);
        check("v3_done_vec",   {24'b0, vector}, 32'h40);
        check("v3_done_level", {29'b0, level}, 32'd3);
        check("v3_done_as",    {31'b0, iack_as_n}, 32'd1);
        check("v3_done_rd",    {31'b0, iack_rd}, 32'd0);
        cyc(1);
        check("v3_vv_single", {31'b0, vector_valid}, 32'd0);
        check("v3_idle_busy", {31'b0, busy}, 32'd0);
        count_busy(8, hits);
        check("v3_no_reaccept", hits, 32'd0);

        // Autovector level 5, dtack and avec together
        mask = 3'd0; ipl_n = 3'b010;
        wait_as_low("av5_strobe");
        ipl_n = 3'b111; dtack = 1'b1; avec = 1'b1; data_in = 16'h0077;
        cyc(1);
        dtack = 1'b0; avec = 1'b0; data_in = '0;
        check("av5_vv",    {31'b0, vector_valid}, 32'd1);
        check("av5_vec",   {24'b0, vector}, 32'd29);
        check("av5_level", {29'b0, level}, 32'd5);
        cyc(6);

        // Masked level 6, then NMI edge behaviour
        mask = 3'd6; ipl_n = 3'b001;
        count_busy(20, hits);
        check("l6_masked", hits, 32'd0);
        mask = 3'd7; ipl_n = 3'b000;
        wait_as_low("nmi1_strobe");
        dtack = 1'b1; data_in = 16'h12AB;
        cyc(1);
        dtack = 1'b0; data_in = '0;
        check("nmi1_vec",   {24'b0, vector}, 32'hAB);
        check("nmi1_level", {29'b0, level}, 32'd7);
        count_busy(100, hits);
        check("nmi_held_no_reack", hits, 32'd0);
        ipl_n = 3'b111;
        cyc(5);
        ipl_n = 3'b000;
        wait_as_low("nmi2_strobe");
        ipl_n = 3'b111; avec = 1'b1;
        cyc(1);
        avec = 1'b0;
        check("nmi2_vv",  {31'b0, vector_valid}, 32'd1);
        check("nmi2_vec", {24'b0, vector}, 32'd31);
        cyc(6);

        // Timeout at level 4
        mask = 3'd0; ipl_n = 3'b011;
        wait_as_low("tmo_strobe");
        ipl_n = 3'b111;
        n = 0;
        while (iack_as_n === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("tmo_as_cycles", n, 32'd255);
        check("tmo_vv",    {31'b0, vector_valid}, 32'd1);
        check("tmo_vec",   {24'b0, vector}, 32'h18);
        check("tmo_level", {29'b0, level}, 32'd4);
        cyc(6);

        // Bus contention, then reset in the middle of the strobe
        bus_busy = 1'b1; ipl_n = 3'b101;
        wait_busy("bb_accept");
        cyc(9);
        check("bb_still_wait_rd", {31'b0, iack_rd}, 32'd0);
        check("bb_still_busy",    {31'b0, busy}, 32'd1);
        bus_busy = 1'b0;
        cyc(1);
        check("bb_addr_rd",   {31'b0, iack_rd}, 32'd1);
        check("bb_addr_as",   {31'b0, iack_as_n}, 32'd1);
        check("bb_addr_addr", {9'b0, iack_address}, 32'h7FFFFA);
        cyc(1);
        check("bb_strobe_as", {31'b0, iack_as_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_as",    {31'b0, iack_as_n}, 32'd1);
        check("arst_busy",  {31'b0, busy}, 32'd0);
        check("arst_rd",    {31'b0, iack_rd}, 32'd0);
        check("arst_addr",  {9'b0, iack_address}, 32'd0);
        check("arst_vec",   {24'b0, vector}, 32'd0);
        check("arst_level", {29'b0, level}, 32'd0);
        ipl_n = 3'b111;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);

        // One-cycle glitch on the level lines
        mask = 3'd0; ipl_n = 3'b100;
        cyc(1);
        ipl_n = 3'b111;
        count_busy(12, hits);
        check("glitch_rejected", hits, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ack_master.md
IRQ_ACK_MASTER -- requirements
Module: irq_ack_master

Interface
REQ-001 TIMEOUT_CYCLES, default 255, maximum number of clk cycles the acknowledge strobe is held waiting for a response.
REQ-002 SPURIOUS_VECTOR, default 8'h18, vector number returned when the acknowledge times out.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 _reset  in  1  reset, asynchronous assert, active-low.
REQ-005 _ipl  in  3  interrupt priority level lines, active-low; 3'b111 means no request and 3'b000 means level 7.
REQ-006 mask  in  3  current CPU interrupt mask.
REQ-007 bus_busy  in  1  CPU bus cycle in progress; the acknowledge must not start while this is high.
REQ-008 dtack  in  1  vectored acknowledge response.
REQ-009 avec  in  1  autovector acknowledge response.
REQ-010 data_in  in  16  responder data; bits [7:0] carry the vector number.
REQ-011 iack_address  out  23  acknowledge address [23:1].
REQ-012 _iack_as  out  1  acknowledge address strobe, active-low.
REQ-013 iack_rd  out  1  read qualifier for the acknowledge cycle.
REQ-014 vector  out  8  vector number captured at the last acknowledge.
REQ-015 vector_valid  out  1  one-cycle pulse when vector is updated.
REQ-016 level  out  3  level accepted by the last acknowledge.
REQ-017 busy  out  1  acknowledge sequence in progress.

Function
REQ-018 Synchronisation: the level is ~_ipl, passed through a 2-flop synchroniser, and is valid only when two consecutive synchronised samples are equal (debounced level).
REQ-019 Acceptance, levels 1-6: a debounced level is accepted only when it is strictly greater than mask.
REQ-020 Acceptance, level 7: level 7 is edge-triggered and is accepted regardless of mask, only while nmi_armed=1.
REQ-021 nmi_armed is cleared when a level-7 request is accepted, and set again when the debounced level is below 7.
REQ-022 Acceptance is evaluated only in IDLE; the accepted level is latched into level at acceptance.
REQ-023 State machine: IDLE -> WAIT_BUS (on acceptance) -> ADDR (on the first cycle with bus_busy=0) -> STROBE -> DONE -> IDLE.
REQ-024 ADDR lasts 1 cycle.
- iack_address = {20'hFFFFF, level}.
- iack_rd = 1.
- _iack_as = 1.
REQ-025 STROBE drives _iack_as = 0 and holds the address and iack_rd stable.
- Each cycle, dtack and avec are sampled.
- A timeout counter increments in every STROBE cycle.
REQ-026 Response in STROBE:
- avec=1 -> vector = 8'd24 + level.
- dtack=1 with avec=0 -> vector = data_in[7:0].
- avec has priority when both are asserted in the same cycle.
REQ-027 Timeout: if the counter reaches TIMEOUT_CYCLES with no response, vector = SPURIOUS_VECTOR and the state moves to DONE.
REQ-028 DONE lasts 1 cycle.
- _iack_as = 1, iack_rd = 0.
- vector_valid = 1 for exactly this cycle.
- The counter is cleared.
REQ-029 Latency: vector_valid is asserted exactly 1 cycle after the cycle in STROBE in which the response was sampled.
REQ-030 Outside ADDR and STROBE: iack_address = 0, iack_rd = 0, _iack_as = 1.
REQ-031 busy = 1 in every state except IDLE.
REQ-032 A level change after acceptance does not abort the sequence; the latched level is used throughout.
REQ-033 The timeout counter is 8 bits wide and saturates; it never wraps within STROBE.

Reset
REQ-034 _reset low asynchronously forces:
- state = IDLE, _iack_as = 1, iack_rd = 0, iack_address = 0;
- vector = 0, vector_valid = 0, level = 0, busy = 0;
- nmi_armed = 1, synchroniser flops = 3'b111 (raw), counter = 0.
REQ-035 Reset asserted during STROBE releases _iack_as immediately, without waiting for a clk edge.
REQ-036 The first acceptance is possible no earlier than 3 cycles after _reset deasserts.

Structure
REQ-037 The following belong in a shared package:
- state encoding (IDLE, WAIT_BUS, ADDR, STROBE, DONE);
- IACK_ADDR_HI = 20'hFFFFF;
- AUTOVECTOR_BASE = 8'd24.
REQ-038 One sub-module, ipl_sync, contains the synchroniser, the debounce logic and the nmi_armed logic.

Verification
REQ-039 Vectored level 3: _ipl=3'b100, mask=2, dtack with data_in=16'h0040 in the 2nd STROBE cycle -> iack_address=23'h7FFFFB, vector=8'h40, level=3, single vector_valid pulse.
REQ-040 Autovector level 5: _ipl=3'b010, mask=0, dtack and avec asserted together -> vector=8'd29.
REQ-041 Masked levels: _ipl=3'b001 (level 6) with mask=6 -> no acknowledge. Then _ipl=3'b000 (level 7) with mask=7 -> exactly one acknowledge.
- Level 7 held for 100 cycles -> no second acknowledge.
- Level released to 0, then asserted again at 7 -> a second acknowledge.
REQ-042 Timeout: level 4, no response -> _iack_as low for 255 cycles, then vector=8'h18.
REQ-043 Bus contention and reset mid-operation:
- bus_busy=1 for 10 cycles -> ADDR entered in the cycle after bus_busy falls.
- _reset asserted during STROBE -> _iack_as=1 asynchronously, busy=0.
REQ-044 Glitch rejection: _ipl glitches to 3'b100 for 1 cycle -> no acceptance.
